// File: rtl/bp_me_burst_to_axil.sv
// BedRock Burst IO command/response to AXI4-Lite manager bridge.
// One transaction in flight at a time, so responses return in command order.

package bp_me_burst_to_axil_pkg;

    localparam int paddr_width_gp   = 40;
    localparam int payload_width_gp = 16;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    // Transfer size in bytes is 1 << size.
    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [payload_width_gp-1:0] payload;
        bp_bedrock_msg_size_e        size;
        logic [paddr_width_gp-1:0]   addr;
        logic [3:0]                  subop;
        bp_bedrock_mem_type_e        msg_type;
    } bp_bedrock_mem_header_s;

    localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

endpackage

module bp_me_burst_to_axil
    import bp_me_burst_to_axil_pkg::*;
#(
    parameter int io_data_width_p   = 64,
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic [mem_header_width_gp-1:0] io_cmd_header_i,
    input  logic                           io_cmd_header_v_i,
    input  logic                           io_cmd_has_data_i,
    output logic                           io_cmd_header_ready_and_o,
    input  logic [io_data_width_p-1:0]     io_cmd_data_i,
    input  logic                           io_cmd_data_v_i,
    input  logic                           io_cmd_last_i,
    output logic                           io_cmd_data_ready_and_o,

    output logic [mem_header_width_gp-1:0] io_resp_header_o,
    output logic                           io_resp_header_v_o,
    output logic                           io_resp_has_data_o,
    input  logic                           io_resp_header_ready_and_i,
    output logic [io_data_width_p-1:0]     io_resp_data_o,
    output logic                           io_resp_data_v_o,
    output logic                           io_resp_last_o,
    input  logic                           io_resp_data_ready_and_i,

    output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
    output logic [2:0]                     m_axil_awprot_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,

    output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
    output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,

    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o,

    output logic [axil_addr_width_p-1:0]   m_axil_araddr_o,
    output logic [2:0]                     m_axil_arprot_o,
    output logic                           m_axil_arvalid_o,
    input  logic                           m_axil_arready_i,

    input  logic [axil_data_width_p-1:0]   m_axil_rdata_i,
    input  logic [1:0]                     m_axil_rresp_i,
    input  logic                           m_axil_rvalid_i,
    output logic                           m_axil_rready_o
);

    localparam int axil_bytes_lp    = axil_data_width_p / 8;
    localparam int io_bytes_lp      = io_data_width_p / 8;
    localparam int lg_axil_bytes_lp = $clog2(axil_bytes_lp);

    if ((axil_data_width_p != 32) && (axil_data_width_p != 64)) begin : g_bad_width
        $error("bp_me_burst_to_axil: axil_data_width_p must be 32 or 64");
    end

    typedef enum logic [2:0] {
        e_ready, e_write_data, e_write_req, e_write_resp,
        e_read_addr, e_read_data, e_resp_header, e_resp_data
    } state_e;

    state_e                  state_r, state_n;
    bp_bedrock_mem_header_s  cmd_header, header_r;
    logic                    cmd_is_read, is_read_r;
    logic [io_data_width_p-1:0]   data_r;
    logic [axil_data_width_p-1:0] rdata_r;
    logic                    aw_done_r, w_done_r;
    logic                    aw_hs, w_hs, write_done;
    logic                    hdr_ready, data_ready, aw_v, w_v, b_ready, ar_v, r_ready, resp_hdr_v, resp_data_v;
    int                      nbytes, off;

    // Error responses are deliberately dropped; the BedRock response is sent regardless.
    logic unused_resp;
    assign unused_resp = ^{m_axil_bresp_i, m_axil_rresp_i, io_cmd_has_data_i};

    assign cmd_header  = bp_bedrock_mem_header_s'(io_cmd_header_i);
    assign cmd_is_read = (cmd_header.msg_type == e_bedrock_mem_rd) || (cmd_header.msg_type == e_bedrock_mem_uc_rd);

    // AW and W complete independently; a same-cycle completion counts toward finishing the write.
    assign aw_hs      = (state_r == e_write_req) && !aw_done_r && m_axil_awready_i;
    assign w_hs       = (state_r == e_write_req) && !w_done_r && m_axil_wready_i;
    assign write_done = (state_r == e_write_req) && (aw_done_r || aw_hs) && (w_done_r || w_hs);

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset_i) state_r <= e_ready;
        else         state_r <= state_n;
    end

    // Next-state and handshake-control decode; valids come from state and flags only.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_n     = state_r;
        hdr_ready   = 1'b0;
        data_ready  = 1'b0;
        aw_v        = 1'b0;
        w_v         = 1'b0;
        b_ready     = 1'b0;
        ar_v        = 1'b0;
        r_ready     = 1'b0;
        resp_hdr_v  = 1'b0;
        resp_data_v = 1'b0;
        case (state_r)
            e_ready: begin
                hdr_ready = 1'b1;
                if (io_cmd_header_v_i) state_n = cmd_is_read ? e_read_addr : e_write_data;
            end
            e_write_data: begin
                data_ready = 1'b1;
                if (io_cmd_data_v_i) state_n = e_write_req;
            end
            e_write_req: begin
                aw_v = !aw_done_r;
                w_v  = !w_done_r;
                if (write_done) state_n = e_write_resp;
            end
            e_write_resp: begin
                b_ready = 1'b1;
                if (m_axil_bvalid_i) state_n = e_resp_header;
            end
            e_read_addr: begin
                ar_v = 1'b1;
                if (m_axil_arready_i) state_n = e_read_data;
            end
            e_read_data: begin
                r_ready = 1'b1;
                if (m_axil_rvalid_i) state_n = e_resp_header;
            end
            e_resp_header: begin
                resp_hdr_v = 1'b1;
                if (io_resp_header_ready_and_i) state_n = is_read_r ? e_resp_data : e_ready;
            end
            e_resp_data: begin
                resp_data_v = 1'b1;
                if (io_resp_data_ready_and_i) state_n = e_ready;
            end
            default: state_n = e_ready;
        endcase
    end

    // Reset forces every handshake output low in the cycle it is sampled.
    assign io_cmd_header_ready_and_o = !reset_i && hdr_ready;
    assign io_cmd_data_ready_and_o   = !reset_i && data_ready;
    assign m_axil_awvalid_o          = !reset_i && aw_v;
    assign m_axil_wvalid_o           = !reset_i && w_v;
    assign m_axil_bready_o           = !reset_i && b_ready;
    assign m_axil_arvalid_o          = !reset_i && ar_v;
    assign m_axil_rready_o           = !reset_i && r_ready;
    assign io_resp_header_v_o        = !reset_i && resp_hdr_v;
    assign io_resp_data_v_o          = !reset_i && resp_data_v;
    assign io_resp_has_data_o        = is_read_r;
    assign io_resp_last_o            = 1'b1;
    assign io_resp_header_o          = header_r;
    assign m_axil_awprot_o           = 3'b000;
    assign m_axil_arprot_o           = 3'b000;
    assign m_axil_awaddr_o           = header_r.addr[axil_addr_width_p-1:0];
    assign m_axil_araddr_o           = header_r.addr[axil_addr_width_p-1:0];

    // Control flags: AW/W completion tracking and read/write direction.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            is_read_r <= 1'b0;
        end else begin
            if (io_cmd_header_v_i && io_cmd_header_ready_and_o) is_read_r <= cmd_is_read;
            if (write_done) begin
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_r <= 1'b1;
                if (w_hs)  w_done_r  <= 1'b1;
            end
        end
    end

    // Captured header and data payloads.
    always_ff @(posedge clk_i) begin
        // NOTE: payload registers carry no reset; they are only read after a handshake has loaded them.
        if (io_cmd_header_v_i && io_cmd_header_ready_and_o) header_r <= cmd_header;
        if (io_cmd_data_v_i && io_cmd_data_ready_and_o)     data_r   <= io_cmd_data_i;
        if (m_axil_rvalid_i && m_axil_rready_o)             rdata_r  <= m_axil_rdata_i;
    end

    assign nbytes = 1 << header_r.size;
    assign off    = int'(header_r.addr[lg_axil_bytes_lp-1:0]);

    // Write lanes: low nbytes replicated across the bus, strobes cover the addressed bytes.
    always_comb begin
        m_axil_wdata_o = '0;
        m_axil_wstrb_o = '0;
        for (int i = 0; i < axil_bytes_lp; i++) begin
            m_axil_wdata_o[8*i+:8] = data_r[8*(i & (nbytes - 1))+:8];
            m_axil_wstrb_o[i]      = (i >= off) && (i < off + nbytes);
        end
    end

    // Read lanes: shift the addressed bytes down, then replicate across the BedRock beat.
    logic [axil_data_width_p-1:0] rdata_shift;
    always_comb begin
        rdata_shift    = rdata_r >> (8 * off);
        io_resp_data_o = '0;
        for (int i = 0; i < io_bytes_lp; i++) begin
            io_resp_data_o[8*i+:8] = rdata_shift[8*(i & (nbytes - 1) & (axil_bytes_lp - 1))+:8];
        end
    end

`ifndef SYNTHESIS
    // Protocol checks on incoming commands.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            if (io_cmd_header_v_i && io_cmd_header_ready_and_o) begin
                assert ((cmd_header.msg_type == e_bedrock_mem_rd) || (cmd_header.msg_type == e_bedrock_mem_uc_rd)
                     || (cmd_header.msg_type == e_bedrock_mem_wr) || (cmd_header.msg_type == e_bedrock_mem_uc_wr))
                    else $error("bp_me_burst_to_axil: unsupported msg_type %0d", cmd_header.msg_type);
                assert ((1 << cmd_header.size) <= axil_bytes_lp)
                    else $error("bp_me_burst_to_axil: size exceeds AXIL width");
                assert ((int'(cmd_header.addr[lg_axil_bytes_lp-1:0]) & ((1 << cmd_header.size) - 1)) == 0)
                    else $error("bp_me_burst_to_axil: misaligned access");
            end
            if (io_cmd_data_v_i) begin
                assert (io_cmd_last_i) else $error("bp_me_burst_to_axil: multi-beat command");
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_me_burst_to_axil.sv
// Directed bench for bp_me_burst_to_axil: writes, reads, backpressure and mid-transaction reset.
module tb_bp_me_burst_to_axil;
    import bp_me_burst_to_axil_pkg::*;

    logic clk_i = 1'b0;
    logic reset_i;
    logic [mem_header_width_gp-1:0] io_cmd_header_i;
    logic io_cmd_header_v_i, io_cmd_has_data_i, io_cmd_header_ready_and_o;
    logic [63:0] io_cmd_data_i;
    logic io_cmd_data_v_i, io_cmd_last_i, io_cmd_data_ready_and_o;
    logic [mem_header_width_gp-1:0] io_resp_header_o;
    logic io_resp_header_v_o, io_resp_has_data_o, io_resp_header_ready_and_i;
    logic [63:0] io_resp_data_o;
    logic io_resp_data_v_o, io_resp_last_o, io_resp_data_ready_and_i;
    logic [31:0] m_axil_awaddr_o;
    logic [2:0]  m_axil_awprot_o;
    logic m_axil_awvalid_o, m_axil_awready_i;
    logic [31:0] m_axil_wdata_o;
    logic [3:0]  m_axil_wstrb_o;
    logic m_axil_wvalid_o, m_axil_wready_i;
    logic [1:0]  m_axil_bresp_i;
    logic m_axil_bvalid_i, m_axil_bready_o;
    logic [31:0] m_axil_araddr_o;
    logic [2:0]  m_axil_arprot_o;
    logic m_axil_arvalid_o, m_axil_arready_i;
    logic [31:0] m_axil_rdata_i;
    logic [1:0]  m_axil_rresp_i;
    logic m_axil_rvalid_i, m_axil_rready_o;

    int total = 0;
    int bad   = 0;

    bp_me_burst_to_axil dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .io_cmd_header_i(io_cmd_header_i), .io_cmd_header_v_i(io_cmd_header_v_i),
        .io_cmd_has_data_i(io_cmd_has_data_i), .io_cmd_header_ready_and_o(io_cmd_header_ready_and_o),
        .io_cmd_data_i(io_cmd_data_i), .io_cmd_data_v_i(io_cmd_data_v_i),
        .io_cmd_last_i(io_cmd_last_i), .io_cmd_data_ready_and_o(io_cmd_data_ready_and_o),
        .io_resp_header_o(io_resp_header_o), .io_resp_header_v_o(io_resp_header_v_o),
        .io_resp_has_data_o(io_resp_has_data_o), .io_resp_header_ready_and_i(io_resp_header_ready_and_i),
        .io_resp_data_o(io_resp_data_o), .io_resp_data_v_o(io_resp_data_v_o),
        .io_resp_last_o(io_resp_last_o), .io_resp_data_ready_and_i(io_resp_data_ready_and_i),
        .m_axil_awaddr_o(m_axil_awaddr_o), .m_axil_awprot_o(m_axil_awprot_o),
        .m_axil_awvalid_o(m_axil_awvalid_o), .m_axil_awready_i(m_axil_awready_i),
        .m_axil_wdata_o(m_axil_wdata_o), .m_axil_wstrb_o(m_axil_wstrb_o),
        .m_axil_wvalid_o(m_axil_wvalid_o), .m_axil_wready_i(m_axil_wready_i),
        .m_axil_bresp_i(m_axil_bresp_i), .m_axil_bvalid_i(m_axil_bvalid_i), .m_axil_bready_o(m_axil_bready_o),
        .m_axil_araddr_o(m_axil_araddr_o), .m_axil_arprot_o(m_axil_arprot_o),
        .m_axil_arvalid_o(m_axil_arvalid_o), .m_axil_arready_i(m_axil_arready_i),
        .m_axil_rdata_i(m_axil_rdata_i), .m_axil_rresp_i(m_axil_rresp_i),
        .m_axil_rvalid_i(m_axil_rvalid_i), .m_axil_rready_o(m_axil_rready_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    function automatic bp_bedrock_mem_header_s mk(input bp_bedrock_mem_type_e t,
                                                  input bp_bedrock_msg_size_e s,
                                                  input logic [39:0] a);
        bp_bedrock_mem_header_s h;
        h          = '0;
        h.msg_type = t;
        h.size     = s;
        h.addr     = a;
        h.payload  = 16'h5a3c;
        return h;
    endfunction

    // Present a header and hold it until accepted (bounded wait).
    task automatic send_header(input bp_bedrock_mem_header_s h, input logic hd);
        io_cmd_header_i   = h;
        io_cmd_has_data_i = hd;
        io_cmd_header_v_i = 1'b1;
        for (int n = 0; n < 20 && !io_cmd_header_ready_and_o; n++) step();
        check("cmd_hdr_ready", io_cmd_header_ready_and_o, 1'b1);
        step();
        io_cmd_header_v_i = 1'b0;
    endtask

    task automatic send_data(input logic [63:0] d);
        io_cmd_data_i   = d;
        io_cmd_last_i   = 1'b1;
        io_cmd_data_v_i = 1'b1;
        for (int n = 0; n < 20 && !io_cmd_data_ready_and_o; n++) step();
        check("cmd_data_ready", io_cmd_data_ready_and_o, 1'b1);
        step();
        io_cmd_data_v_i = 1'b0;
    endtask

    // Full read with arready high; one cycle of rvalid; checks the returned beat.
    task automatic do_read(input bp_bedrock_mem_header_s h, input logic [31:0] rd, input logic [63:0] exp_data);
        send_header(h, 1'b0);
        check("rd_arvalid", m_axil_arvalid_o, 1'b1);
        check("rd_araddr", m_axil_araddr_o, h.addr[31:0]);
        check("rd_arprot", m_axil_arprot_o, 3'b000);
        check("rd_rready_early", m_axil_rready_o, 1'b0);
        step();
        check("rd_arvalid_drop", m_axil_arvalid_o, 1'b0);
        check("rd_rready", m_axil_rready_o, 1'b1);
        m_axil_rvalid_i = 1'b1;
        m_axil_rdata_i  = rd;
        step();
        m_axil_rvalid_i = 1'b0;
        check("rd_hdr_v", io_resp_header_v_o, 1'b1);
        check("rd_hdr", io_resp_header_o, h);
        check("rd_has_data", io_resp_has_data_o, 1'b1);
        check("rd_data_v_early", io_resp_data_v_o, 1'b0);
        step();
        check("rd_data_v", io_resp_data_v_o, 1'b1);
        check("rd_data", io_resp_data_o, exp_data);
        check("rd_last", io_resp_last_o, 1'b1);
        step();
        check("rd_done_ready", io_cmd_header_ready_and_o, 1'b1);
        check("rd_done_data_v", io_resp_data_v_o, 1'b0);
    endtask

    bp_bedrock_mem_header_s h1, h2, h3, h4, h5, h6, h7;
    int b_hs;

    initial begin
        reset_i = 1'b1;
        io_cmd_header_i = '0; io_cmd_header_v_i = 1'b0; io_cmd_has_data_i = 1'b0;
        io_cmd_data_i = '0; io_cmd_data_v_i = 1'b0; io_cmd_last_i = 1'b1;
        io_resp_header_ready_and_i = 1'b1; io_resp_data_ready_and_i = 1'b1;
        m_axil_awready_i = 1'b1; m_axil_wready_i = 1'b1; m_axil_arready_i = 1'b1;
        m_axil_bresp_i = 2'b00; m_axil_bvalid_i = 1'b0;
        m_axil_rdata_i = '0; m_axil_rresp_i = 2'b00; m_axil_rvalid_i = 1'b0;

        // Reset state
        step(); step();
        check("rst_hdr_ready", io_cmd_header_ready_and_o, 1'b0);
        check("rst_awvalid", m_axil_awvalid_o, 1'b0);
        check("rst_resp_v", io_resp_header_v_o, 1'b0);
        reset_i = 1'b0;
        step();
        check("post_rst_hdr_ready", io_cmd_header_ready_and_o, 1'b1);
        check("post_rst_data_ready", io_cmd_data_ready_and_o, 1'b0);

        // Write, AW and W same cycle
        h1 = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_4, 40'h1000);
        send_header(h1, 1'b1);
        send_data(64'h00000000_DEADBEEF);
        check("w1_awvalid", m_axil_awvalid_o, 1'b1);
        check("w1_wvalid", m_axil_wvalid_o, 1'b1);
        check("w1_awaddr", m_axil_awaddr_o, 32'h1000);
        check("w1_awprot", m_axil_awprot_o, 3'b000);
        check("w1_wdata", m_axil_wdata_o, 32'hDEADBEEF);
        check("w1_wstrb", m_axil_wstrb_o, 4'hF);
        step();
        check("w1_awvalid_drop", m_axil_awvalid_o, 1'b0);
        check("w1_wvalid_drop", m_axil_wvalid_o, 1'b0);
        check("w1_bready", m_axil_bready_o, 1'b1);
        m_axil_bvalid_i = 1'b1;
        step();
        m_axil_bvalid_i = 1'b0;
        check("w1_hdr_v", io_resp_header_v_o, 1'b1);
        check("w1_hdr", io_resp_header_o, h1);
        check("w1_has_data", io_resp_has_data_o, 1'b0);
        step();
        check("w1_hdr_v_drop", io_resp_header_v_o, 1'b0);
        check("w1_ready_again", io_cmd_header_ready_and_o, 1'b1);

        // Write, independent channels: W first, AW delayed
        h2 = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_1, 40'h1003);
        m_axil_awready_i = 1'b0;
        send_header(h2, 1'b1);
        send_data(64'h11223344_556677A5);
        check("w2_awvalid", m_axil_awvalid_o, 1'b1);
        check("w2_wvalid", m_axil_wvalid_o, 1'b1);
        check("w2_awaddr", m_axil_awaddr_o, 32'h1003);
        check("w2_wdata", m_axil_wdata_o, 32'hA5A5A5A5);
        check("w2_wstrb", m_axil_wstrb_o, 4'h8);
        for (int k = 0; k < 3; k++) begin
            step();
            check("w2_wvalid_held_low", m_axil_wvalid_o, 1'b0);
            check("w2_awvalid_held", m_axil_awvalid_o, 1'b1);
            check("w2_bready_wait", m_axil_bready_o, 1'b0);
        end
        m_axil_awready_i = 1'b1;
        step();
        check("w2_awvalid_drop", m_axil_awvalid_o, 1'b0);
        check("w2_bready", m_axil_bready_o, 1'b1);
        b_hs = 0;
        m_axil_bvalid_i = 1'b1;
        if (m_axil_bready_o) b_hs++;
        step();
        if (m_axil_bready_o) b_hs++;
        m_axil_bvalid_i = 1'b0;
        check("w2_b_count", b_hs, 1);
        check("w2_hdr_v", io_resp_header_v_o, 1'b1);
        check("w2_hdr", io_resp_header_o, h2);
        step();

        // Reads
        h3 = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_4, 40'h2000);
        do_read(h3, 32'h12345678, 64'h12345678_12345678);
        h4 = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_2, 40'h2002);
        do_read(h4, 32'hCAFEBABE, 64'hCAFECAFE_CAFECAFE);

        // Response header backpressure with a second command pending
        io_resp_header_ready_and_i = 1'b0;
        h5 = mk(e_bedrock_mem_wr, e_bedrock_msg_size_2, 40'h3004);
        send_header(h5, 1'b1);
        send_data(64'h0000_0000_0000_BEEF);
        check("bp_wstrb", m_axil_wstrb_o, 4'h3);
        check("bp_wdata", m_axil_wdata_o, 32'hBEEFBEEF);
        step();
        m_axil_bvalid_i = 1'b1;
        step();
        m_axil_bvalid_i = 1'b0;
        h6 = mk(e_bedrock_mem_rd, e_bedrock_msg_size_4, 40'h4000);
        io_cmd_header_i   = h6;
        io_cmd_has_data_i = 1'b0;
        io_cmd_header_v_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("bp_hdr_v_stable", io_resp_header_v_o, 1'b1);
            check("bp_hdr_stable", io_resp_header_o, h5);
            check("bp_cmd_blocked", io_cmd_header_ready_and_o, 1'b0);
            step();
        end
        io_resp_header_ready_and_i = 1'b1;
        step();
        check("bp_next_ready", io_cmd_header_ready_and_o, 1'b1);
        check("bp_hdr_v_drop", io_resp_header_v_o, 1'b0);
        step();
        io_cmd_header_v_i = 1'b0;
        check("bp_next_arvalid", m_axil_arvalid_o, 1'b1);
        check("bp_next_araddr", m_axil_araddr_o, 32'h4000);
        step();
        m_axil_rvalid_i = 1'b1;
        m_axil_rdata_i  = 32'h0BADF00D;
        step();
        m_axil_rvalid_i = 1'b0;
        check("bp_next_hdr", io_resp_header_o, h6);
        step();
        check("bp_next_data", io_resp_data_o, 64'h0BADF00D_0BADF00D);
        step();

        // Reset in the middle of a write
        m_axil_awready_i = 1'b0;
        m_axil_wready_i  = 1'b0;
        h7 = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_4, 40'h5000);
        send_header(h7, 1'b1);
        send_data(64'h55);
        check("rst2_awvalid_before", m_axil_awvalid_o, 1'b1);
        reset_i = 1'b1;
        step();
        check("rst2_awvalid", m_axil_awvalid_o, 1'b0);
        check("rst2_wvalid", m_axil_wvalid_o, 1'b0);
        check("rst2_hdr_ready", io_cmd_header_ready_and_o, 1'b0);
        check("rst2_resp_v", io_resp_header_v_o, 1'b0);
        reset_i          = 1'b0;
        m_axil_awready_i = 1'b1;
        m_axil_wready_i  = 1'b1;
        m_axil_bvalid_i  = 1'b1;
        step();
        check("rst2_hdr_ready_after", io_cmd_header_ready_and_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("rst2_no_aw", m_axil_awvalid_o, 1'b0);
            check("rst2_no_b", m_axil_bready_o, 1'b0);
            check("rst2_no_resp", io_resp_header_v_o, 1'b0);
            step();
        end
        m_axil_bvalid_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_me_burst_to_axil.md
Name: bp_me_burst_to_axil

Overview:
- Converts a BedRock Burst IO command input and response output into an AXI4-Lite Manager port.
- Lets BP drive AXI4-Lite peripherals with uncached loads and stores.
- Handles one transaction at a time: command accepted, AXIL transaction completed, BedRock response returned, then the next command is accepted. Responses are therefore in order by construction.

Parameters:
- bp_params_p, e_bp_default_cfg, BP configuration; supplies paddr/did/lce widths and mem_header_width_lp.
- io_data_width_p, (cce_type_p == e_cce_uce) ? uce_fill_width_p : bedrock_data_width_p, BedRock data beat width.
- axil_data_width_p, 32, AXIL data width; only 32 or 64 are legal (elaboration $error otherwise).
- axil_addr_width_p, 32, AXIL address width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- io_cmd_header_i  in  mem_header_width_lp  BedRock command header.
- io_cmd_header_v_i  in  1  header valid.
- io_cmd_has_data_i  in  1  command carries data.
- io_cmd_header_ready_and_o  out  1  header ready.
- io_cmd_data_i  in  io_data_width_p  command data, LSB-justified.
- io_cmd_data_v_i  in  1  data valid.
- io_cmd_last_i  in  1  last beat; must be 1.
- io_cmd_data_ready_and_o  out  1  data ready.
- io_resp_header_o  out  mem_header_width_lp  response header.
- io_resp_header_v_o  out  1  header valid.
- io_resp_has_data_o  out  1  1 for reads.
- io_resp_header_ready_and_i  in  1  header ready.
- io_resp_data_o  out  io_data_width_p  read data.
- io_resp_data_v_o  out  1  data valid.
- io_resp_last_o  out  1  always 1.
- io_resp_data_ready_and_i  in  1  data ready.
- m_axil_awaddr_o/awprot_o/awvalid_o/awready_i  out/out/out/in  axil_addr_width_p/3/1/1  write address channel.
- m_axil_wdata_o/wstrb_o/wvalid_o/wready_i  out/out/out/in  axil_data_width_p/axil_data_width_p>>3/1/1  write data channel.
- m_axil_bresp_i/bvalid_i/bready_o  in/in/out  2/1/1  write response channel.
- m_axil_araddr_o/arprot_o/arvalid_o/arready_i  out/out/out/in  axil_addr_width_p/3/1/1  read address channel.
- m_axil_rdata_i/rresp_i/rvalid_i/rready_o  in/in/in/out  axil_data_width_p/2/1/1  read data channel.

Behaviour:
- FSM states: e_ready, e_write_data, e_write_req, e_write_resp, e_read_addr, e_read_data, e_resp_header, e_resp_data.
- Reset: state resets to e_ready.
  - All valid/ready outputs are 0 in the cycle reset is sampled and for as long as it is held.
  - The one exception is io_cmd_header_ready_and_o, which is 1 in e_ready after reset deasserts.
  - Reset mid-transaction abandons the transaction; no response is generated.
- Valid outputs are decoded only from the state and the latched header/data registers; they never depend on any ready input.
- awprot_o and arprot_o are 3'b000.
- e_ready: header_ready=1. On header handshake, latch the header.
  - msg_type uc_wr or wr -> e_write_data.
  - msg_type uc_rd or rd -> e_read_addr.
  - Any other type is a simulation assertion error.
- e_write_data: data_ready=1. On handshake, latch data -> e_write_req.
- e_write_req: awvalid=~aw_done, wvalid=~w_done.
  - aw_done and w_done are flags that set on their own handshake, so AW and W may complete in either order or in the same cycle.
  - When both are done (counting a same-cycle completion): clear both flags -> e_write_resp.
- e_write_resp: bready=1. On b handshake -> e_resp_header.
- e_read_addr: arvalid=1. On handshake -> e_read_data.
- e_read_data: rready=1. On handshake, latch rdata -> e_resp_header.
- e_resp_header: header_v=1, header = latched command header unchanged, has_data = is-read.
  - On handshake: read -> e_resp_data; write -> e_ready.
- e_resp_data: data_v=1, last=1. On handshake -> e_ready.
- Addressing:
  - awaddr/araddr = header addr truncated to axil_addr_width_p, passed unaligned.
  - off = addr[log2(axil_data_width_p/8)-1:0].
  - nbytes = 1 << size.
- Write data and strobes:
  - wdata = the low nbytes of cmd data replicated across the bus.
  - wstrb = ((1<<nbytes)-1) << off.
- Read data: (rdata >> 8*off), low nbytes replicated to fill io_data_width_p.
- Errors:
  - bresp/rresp values are ignored; the response is still returned.
  - size > axil bytes, misaligned (off % nbytes != 0), or io_cmd_last_i=0 with data valid are assertion errors.
- Minimum latency with all readys high: write header cycle 0 -> response header valid cycle 4; read -> response header valid cycle 3, data cycle 4.

Test Plan:
- Write, AW and W same cycle: uc_wr size 4, addr 0x1000, data 0xDEADBEEF -> awaddr 0x1000, wdata 0xDEADBEEF, wstrb 0xF. After bvalid: response header uc_wr, addr 0x1000, has_data 0.
- Write, independent channels: uc_wr size 1, addr 0x1003, data 0xA5; awready held low 3 cycles after wready -> wvalid drops after its handshake, awvalid stays high until awready. Bus shows wdata 0xA5A5A5A5, wstrb 0x8. Exactly one b accepted.
- Read: uc_rd size 4, addr 0x2000, rdata 0x12345678 -> response header has_data 1, data = 0x12345678 replicated, last 1.
- Sub-word read: uc_rd size 2, addr 0x2002, rdata 0xCAFEBABE -> response data = 0xCAFE replicated.
- Backpressure: response header ready low 10 cycles -> header and valid stable; io_cmd_header_ready_and_o=0; a second pending command is accepted the cycle after the response completes.
- Reset in e_write_req with awvalid high -> next cycle all valids 0; after release, header_ready=1 and no response emitted.
